sevseg_scan_ctrl: RTL

Time-multiplexed scan controller for a bank of common-anode seven-segment digits. It owns one shared `sevseg_decoder` instance and sequences it across `NUM_DIGITS` digits, one digit at a time. Each digit slot starts with a blanking interval that suppresses ghosting. New display values are double-buffered and committed only at frame boundaries, so a displayed frame never mixes old and new digits.

---
 rtl/sevseg_pkg.sv | 16 +
 rtl/sevseg_decoder.sv | 30 +++
 rtl/sevseg_scan_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/sevseg_pkg.sv
// sevseg_pkg: shared types, constants and width helper for the seven-segment scan controller.
package sevseg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        SHOW
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic int width_of(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sevseg_decoder.sv
// sevseg_decoder: hex nibble to active-low {a,b,c,d,e,f,g} segment pattern.
module sevseg_decoder (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'h7F;
        case (nibble)
            4'h0: seg = 7'h01;
            4'h1: seg = 7'h4F;
            4'h2: seg = 7'h12;
            4'h3: seg = 7'h06;
            4'h4: seg = 7'h4C;
            4'h5: seg = 7'h24;
            4'h6: seg = 7'h20;
            4'h7: seg = 7'h0F;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h04;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h60;
            4'hC: seg = 7'h31;
            4'hD: seg = 7'h42;
            4'hE: seg = 7'h30;
            4'hF: seg = 7'h38;
            default: seg = 7'h7F;
        endcase
    end

endmodule

// File: rtl/sevseg_scan_ctrl.sv
// sevseg_scan_ctrl: time-multiplexed seven-segment scanner with frame-aligned double buffering.
// Define SEVSEG_LZ_BLANK_EN to blank leading-zero digits (digit 0 always shown).
module sevseg_scan_ctrl
    import sevseg_pkg::*;
#(
    parameter int   NUM_DIGITS   = 4,
    parameter int   SLOT_CYCLES  = 50000,
    parameter int   BLANK_CYCLES = 500,
    parameter logic DIGIT_ON     = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   value,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    output logic [6:0]                seg,
    output logic                      dp,
    output logic [NUM_DIGITS-1:0]     dig_en,
    output logic                      pending,
    output logic                      frame_done
);

    localparam int CW = width_of(SLOT_CYCLES);
    localparam int IW = width_of(NUM_DIGITS);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] SHOW_LAST  = CW'(SLOT_CYCLES - BLANK_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] DIG_OFF = {NUM_DIGITS{~DIGIT_ON}};

    state_t                    state, state_nx;
    logic [CW-1:0]             cnt, cnt_nx;
    logic [IW-1:0]             idx, idx_nx;
    logic [4*NUM_DIGITS-1:0]   active, shadow;
    logic [NUM_DIGITS-1:0]     active_dp, shadow_dp;
    logic                      commit, lz, show_nx;
    logic [6:0]                dec_seg;

    sevseg_decoder u_dec (
        .nibble (active[4*idx +: 4]),
        .seg    (dec_seg)
    );

`ifdef SEVSEG_LZ_BLANK_EN
    assign lz = (idx != '0) && ((active >> {idx, 2'b00}) == '0);
`else
    assign lz = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + 1'b1;
        idx_nx   = idx;
        commit   = 1'b0;
        if (!enable) begin
            state_nx = IDLE;
            cnt_nx   = '0;
            idx_nx   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nx = BLANK;
                    cnt_nx   = '0;
                end
                BLANK: if (cnt == BLANK_LAST) begin
                    state_nx = SHOW;
                    cnt_nx   = '0;
                end
                SHOW: if (cnt == SHOW_LAST) begin
                    state_nx = BLANK;
                    cnt_nx   = '0;
                    commit   = (idx == IDX_LAST);
                    idx_nx   = commit ? '0 : idx + 1'b1;
                end
                default: begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                    idx_nx   = '0;
                end
            endcase
        end
    end

    // idx only moves on the way out of SHOW, so while show_nx holds the decoder already sees the slot's digit
    assign show_nx = (state_nx == SHOW) && !lz;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            active     <= '0;
            active_dp  <= '0;
            shadow     <= '0;
            shadow_dp  <= '0;
            pending    <= 1'b0;
            frame_done <= 1'b0;
            seg        <= SEG_BLANK;
            dp         <= 1'b1;
            dig_en     <= DIG_OFF;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            idx        <= idx_nx;
            frame_done <= commit;
            seg        <= show_nx ? dec_seg : SEG_BLANK;
            dp         <= show_nx ? ~active_dp[idx] : 1'b1;
            dig_en     <= show_nx ? DIG_OFF ^ (NUM_DIGITS'(1) << idx) : DIG_OFF;
            pending    <= !commit && (load || pending);
            if (load) begin
                shadow    <= value;
                shadow_dp <= dp_in;
            end
            if (commit) begin
                active    <= load ? value : shadow;
                active_dp <= load ? dp_in : shadow_dp;
            end
        end
    end

endmodule
